// File: rtl/trig_fmt_pkg.sv
// Shared types and constants for the trig-to-BCD display formatter.
// The nibble adjust helper is the "add 3 if >= 5" step of double-dabble.
package trig_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    CONVERT,
    COMMIT
  } fmt_state_t;

  localparam int SCALE_K    = 1000;
  localparam int BIN_W      = 10;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int ITER_MAX   = 10;
  localparam int ITER_W     = $clog2(ITER_MAX + 1);
  localparam int PROD_W     = 26;
  localparam int SAMPLE_W   = 16;
  localparam int CHANNELS   = 2;

  typedef logic [3:0] bcd_nibble_t;

  function automatic bcd_nibble_t dabble_adjust(input bcd_nibble_t n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: loads a BIN_W-bit value on start, then performs
// one adjust-and-shift per clock for ITER_MAX clocks and raises done.
module bin_to_bcd_seq
  import trig_fmt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  logic [BCD_W-1:0]  bcd_reg;
  logic [BIN_W-1:0]  bin_reg;
  logic [ITER_W-1:0] iter_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [BCD_W-1:0]  adj;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = dabble_adjust(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_reg  <= '0;
      bin_reg  <= '0;
      iter_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      bcd_reg  <= '0;
      bin_reg  <= bin;
      iter_reg <= '0;
      busy_reg <= 1'b1;
      done_reg <= 1'b0;
    end else if (busy_reg) begin
      // Binary bits shift out of bin_reg into the adjusted BCD digits.
      {bcd_reg, bin_reg} <= {adj, bin_reg} << 1;
      iter_reg           <= iter_reg + ITER_W'(1);
      if (iter_reg == ITER_W'(ITER_MAX - 1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign bcd  = bcd_reg;
  assign done = done_reg;

endmodule

// File: rtl/trig_bcd_formatter.sv
// Converts signed Q1.FRAC_BITS sine/cosine samples into X.XXX BCD magnitudes
// plus sign flags for the seven-segment driver; outputs change only at COMMIT.
module trig_bcd_formatter
  import trig_fmt_pkg::*;
#(
  parameter int FRAC_BITS = 14,
  parameter int ROUND_EN  = 1
) (
  input  logic                clock_100Mhz,
  input  logic                reset,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sin_in,
  input  logic [SAMPLE_W-1:0] cos_in,
  output logic [BCD_W-1:0]    sine,
  output logic [BCD_W-1:0]    cosine,
  output logic                sine_neg,
  output logic                cosine_neg,
  output logic                update
);

  localparam logic [SAMPLE_W:0]   FULL_SCALE = (SAMPLE_W + 1)'(1 << FRAC_BITS);
  localparam logic [PROD_W-1:0]   ROUND_OFS  =
    (ROUND_EN != 0) ? PROD_W'(1 << (FRAC_BITS - 1)) : PROD_W'(0);

  // Magnitude saturated to full scale (covers -32768 and out-of-range codes),
  // then scaled to thousandths with optional half-up rounding.
  function automatic logic [BIN_W-1:0] scale_thousandths(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W:0]  mag;
    logic [PROD_W-1:0]  prod;
    mag = x[SAMPLE_W-1] ? ((SAMPLE_W + 1)'(0) - {1'b1, x}) : {1'b0, x};
    if (mag > FULL_SCALE) begin
      mag = FULL_SCALE;
    end
    prod = PROD_W'(mag) * PROD_W'(SCALE_K) + ROUND_OFS;
    return BIN_W'(prod >> FRAC_BITS);
  endfunction

  fmt_state_t state, next_state;

  logic [CHANNELS-1:0][SAMPLE_W-1:0] sample_reg;
  logic [CHANNELS-1:0][BIN_W-1:0]    scaled;
  logic [CHANNELS-1:0][BCD_W-1:0]    bcd;
  logic [CHANNELS-1:0]               done;
  logic [CHANNELS-1:0]               neg_pend_reg;
  logic [CHANNELS-1:0][BCD_W-1:0]    bcd_out_reg;
  logic [CHANNELS-1:0]               neg_out_reg;
  logic [ITER_W-1:0]                 iter_reg;
  logic                              ready_reg;
  logic                              update_reg;
  logic                              capture;
  logic                              commit;
  logic                              conv_start;

  // Channel 0 is sine, channel 1 is cosine; both share the FSM's start.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign scaled[gi] = scale_thousandths(sample_reg[gi]);

      bin_to_bcd_seq u_conv (
        .clk   (clock_100Mhz),
        .rst   (reset),
        .start (conv_start),
        .bin   (scaled[gi]),
        .bcd   (bcd[gi]),
        .done  (done[gi])
      );
    end
  endgenerate

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    commit     = 1'b0;
    conv_start = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          capture    = 1'b1;
          next_state = SCALE;
        end
      end
      SCALE: begin
        conv_start = 1'b1;
        next_state = CONVERT;
      end
      CONVERT: begin
        if (iter_reg == ITER_W'(ITER_MAX - 1)) begin
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        commit     = &done;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sample_reg   <= '0;
      neg_pend_reg <= '0;
      bcd_out_reg  <= '0;
      neg_out_reg  <= '0;
      iter_reg     <= '0;
      ready_reg    <= 1'b1;
      update_reg   <= 1'b0;
    end else begin
      state      <= next_state;
      ready_reg  <= (next_state == IDLE);
      update_reg <= commit;

      if (capture) begin
        sample_reg <= {cos_in, sin_in};
      end

      if (state == SCALE) begin
        iter_reg <= '0;
        // A result that rounds to zero is shown unsigned: no "-0.000".
        for (int i = 0; i < CHANNELS; i++) begin
          neg_pend_reg[i] <= sample_reg[i][SAMPLE_W-1] && (scaled[i] != '0);
        end
      end else if (state == CONVERT) begin
        iter_reg <= iter_reg + ITER_W'(1);
      end

      if (commit) begin
        bcd_out_reg <= bcd;
        neg_out_reg <= neg_pend_reg;
      end
    end
  end

  assign sample_ready = ready_reg;
  assign update       = update_reg;
  assign sine         = bcd_out_reg[0];
  assign cosine       = bcd_out_reg[1];
  assign sine_neg     = neg_out_reg[0];
  assign cosine_neg   = neg_out_reg[1];

endmodule

// File: tb/tb_trig_bcd_formatter.sv
// Directed bench: a rounding and a truncating formatter run in lockstep from
// a vector table, plus hand sequences for back-to-back accepts and mid-conversion reset.
module tb_trig_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] sin_in = 16'h0000;
  logic [15:0] cos_in = 16'h0000;

  logic        ready_r, upd_r, sneg_r, cneg_r;
  logic [15:0] sine_r, cosine_r;
  logic        ready_t, upd_t, sneg_t, cneg_t;
  logic [15:0] sine_t, cosine_t;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  trig_bcd_formatter #(.FRAC_BITS(14), .ROUND_EN(1)) dut (
    .clock_100Mhz (clk),
    .reset        (rst),
    .sample_valid (valid),
    .sample_ready (ready_r),
    .sin_in       (sin_in),
    .cos_in       (cos_in),
    .sine         (sine_r),
    .cosine       (cosine_r),
    .sine_neg     (sneg_r),
    .cosine_neg   (cneg_r),
    .update       (upd_r)
  );

  trig_bcd_formatter #(.FRAC_BITS(14), .ROUND_EN(0)) dut_trunc (
    .clock_100Mhz (clk),
    .reset        (rst),
    .sample_valid (valid),
    .sample_ready (ready_t),
    .sin_in       (sin_in),
    .cos_in       (cos_in),
    .sine         (sine_t),
    .cosine       (cosine_t),
    .sine_neg     (sneg_t),
    .cosine_neg   (cneg_t),
    .update       (upd_t)
  );

  typedef struct {
    logic [15:0] sin_v;
    logic [15:0] cos_v;
    logic [15:0] sine_rnd;
    logic        sneg_rnd;
    logic [15:0] cos_rnd;
    logic        cneg_rnd;
    logic [15:0] sine_trc;
    logic        sneg_trc;
    logic [15:0] cos_trc;
    logic        cneg_trc;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one pair, then watch 14 edges: update must pulse once at edge 12,
  // ready must be low for 12 cycles and outputs must hold until the commit.
  task automatic run_sample(input string tag, input vec_t v);
    int          upd_edge;
    int          upd_cnt;
    int          rdy_low;
    logic        stable;
    logic        lockstep;
    logic [15:0] prev_s;
    logic [15:0] prev_c;
    @(negedge clk);
    check({tag, " ready_before"}, 16'(ready_r), 16'd1);
    sin_in   = v.sin_v;
    cos_in   = v.cos_v;
    valid    = 1'b1;
    prev_s   = sine_r;
    prev_c   = cosine_r;
    upd_edge = -1;
    upd_cnt  = 0;
    rdy_low  = 0;
    stable   = 1'b1;
    lockstep = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      if (e == 0) begin
        valid  = 1'b0;
        sin_in = 16'h5A5A;
        cos_in = 16'hA5A5;
      end
      if (!ready_r) rdy_low++;
      if (upd_r) begin
        upd_cnt++;
        if (upd_edge < 0) upd_edge = e;
      end
      if (e < 12 && (sine_r !== prev_s || cosine_r !== prev_c)) stable = 1'b0;
      if (upd_t !== upd_r || ready_t !== ready_r) lockstep = 1'b0;
    end
    check({tag, " update_edge"}, 16'(upd_edge), 16'd12);
    check({tag, " update_count"}, 16'(upd_cnt), 16'd1);
    check({tag, " ready_low_cycles"}, 16'(rdy_low), 16'd12);
    check({tag, " held_before_commit"}, 16'(stable), 16'd1);
    check({tag, " trunc_lockstep"}, 16'(lockstep), 16'd1);
    check({tag, " sine"}, sine_r, v.sine_rnd);
    check({tag, " sine_neg"}, 16'(sneg_r), 16'(v.sneg_rnd));
    check({tag, " cosine"}, cosine_r, v.cos_rnd);
    check({tag, " cosine_neg"}, 16'(cneg_r), 16'(v.cneg_rnd));
    check({tag, " trunc_sine"}, sine_t, v.sine_trc);
    check({tag, " trunc_sine_neg"}, 16'(sneg_t), 16'(v.sneg_trc));
    check({tag, " trunc_cosine"}, cosine_t, v.cos_trc);
    check({tag, " trunc_cosine_neg"}, 16'(cneg_t), 16'(v.cneg_trc));
    $display("[TB] %s sin=%0d cos=%0d -> sine=%h%s cosine=%h%s", tag,
             $signed(v.sin_v), $signed(v.cos_v), sine_r, sneg_r ? "-" : "+",
             cosine_r, cneg_r ? "-" : "+");
  endtask

  int   upd_cnt;
  int   rdy_low;
  int   upd_edges [$];
  logic [15:0] snap_s;
  logic [15:0] snap_c;
  logic        snap_cn;

  initial begin
    // sin, cos, round: sine/neg cosine/neg, truncate: sine/neg cosine/neg
    vecs[0] = '{16'd16384, 16'd0,        16'h1000, 1'b0, 16'h0000, 1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'd8192,  -16'sd11585,  16'h0500, 1'b0, 16'h0707, 1'b1, 16'h0500, 1'b0, 16'h0707, 1'b1};
    vecs[2] = '{-16'sd32768, 16'd20000,  16'h1000, 1'b1, 16'h1000, 1'b0, 16'h1000, 1'b1, 16'h1000, 1'b0};
    vecs[3] = '{-16'sd1,   16'd12345,    16'h0000, 1'b0, 16'h0753, 1'b0, 16'h0000, 1'b0, 16'h0753, 1'b0};
    vecs[4] = '{16'd9,     -16'sd9,      16'h0001, 1'b0, 16'h0001, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'd16383, -16'sd16384,  16'h1000, 1'b0, 16'h1000, 1'b1, 16'h0999, 1'b0, 16'h1000, 1'b1};
    vecs[6] = '{16'd4096,  16'd5000,     16'h0250, 1'b0, 16'h0305, 1'b0, 16'h0250, 1'b0, 16'h0305, 1'b0};
    vecs[7] = '{16'd32767, -16'sd32767,  16'h1000, 1'b0, 16'h1000, 1'b1, 16'h1000, 1'b0, 16'h1000, 1'b1};

    // Reset state, then a quiet idle stretch.
    repeat (2) @(negedge clk);
    check("reset sine", sine_r, 16'h0000);
    check("reset cosine", cosine_r, 16'h0000);
    check("reset flags", 16'({sneg_r, cneg_r, upd_r}), 16'd0);
    check("reset ready", 16'(ready_r), 16'd1);
    rst = 1'b0;
    upd_cnt = 0;
    rdy_low = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (upd_r) upd_cnt++;
      if (!ready_r) rdy_low++;
    end
    check("idle update_count", 16'(upd_cnt), 16'd0);
    check("idle ready_low", 16'(rdy_low), 16'd0);
    check("idle sine", sine_r, 16'h0000);
    $display("[TB] reset/idle checked");

    for (int i = 0; i < 8; i++) begin
      run_sample($sformatf("vec%0d", i), vecs[i]);
    end

    // Valid held high: A accepted at N, inputs changed while busy, C accepted at N+13.
    @(negedge clk);
    sin_in = 16'd16384;
    cos_in = 16'd0;
    valid  = 1'b1;
    upd_edges.delete();
    snap_s = 16'hFFFF;
    snap_c = 16'hFFFF;
    snap_cn = 1'b0;
    for (int e = 0; e < 27; e++) begin
      @(negedge clk);
      if (e == 0) begin
        sin_in = 16'd4096;
        cos_in = 16'd4096;
      end
      if (e == 5) begin
        sin_in = 16'd8192;
        cos_in = -16'sd11585;
      end
      if (e == 12) check("held ready_at_12", 16'(ready_r), 16'd1);
      if (e == 13) begin
        check("held ready_at_13", 16'(ready_r), 16'd0);
        valid = 1'b0;
      end
      if (upd_r) upd_edges.push_back(e);
      if (e == 12) begin
        check("held first sine", sine_r, 16'h1000);
        check("held first cosine", cosine_r, 16'h0000);
      end
      if (e == 24) begin
        snap_s = sine_r;
        snap_c = cosine_r;
      end
      if (e == 25) snap_cn = cneg_r;
    end
    check("held update_count", 16'(upd_edges.size()), 16'd2);
    if (upd_edges.size() == 2) begin
      check("held update_spacing", 16'(upd_edges[1] - upd_edges[0]), 16'd13);
      check("held first_update_edge", 16'(upd_edges[0]), 16'd12);
    end
    check("held stable sine", snap_s, 16'h1000);
    check("held stable cosine", snap_c, 16'h0000);
    check("held second sine", sine_r, 16'h0500);
    check("held second cosine", cosine_r, 16'h0707);
    check("held second cosine_neg", 16'(snap_cn), 16'd1);
    $display("[TB] held-valid sequence: updates=%0d sine=%h cosine=%h",
             upd_edges.size(), sine_r, cosine_r);

    // Reset across edge N+6 of a conversion: outputs clear, no update follows.
    @(negedge clk);
    sin_in = 16'd16384;
    cos_in = 16'd4096;
    valid  = 1'b1;
    upd_cnt = 0;
    for (int e = 0; e < 21; e++) begin
      @(negedge clk);
      if (e == 0) valid = 1'b0;
      if (e == 5) rst = 1'b1;
      if (e == 6) begin
        check("midreset sine", sine_r, 16'h0000);
        check("midreset cosine", cosine_r, 16'h0000);
        check("midreset flags", 16'({sneg_r, cneg_r, upd_r}), 16'd0);
        check("midreset ready", 16'(ready_r), 16'd1);
        rst = 1'b0;
      end
      if (e > 6 && upd_r) upd_cnt++;
    end
    check("midreset no_update", 16'(upd_cnt), 16'd0);
    check("midreset sine_after", sine_r, 16'h0000);
    $display("[TB] mid-conversion reset checked");

    run_sample("post_reset", '{16'd4096, 16'd0, 16'h0250, 1'b0, 16'h0000, 1'b0,
                               16'h0250, 1'b0, 16'h0000, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
